// File: rtl/zap_cache_ctrl_fsm.sv
// zap_cache_ctrl_fsm
//   Direct-mapped, write-back cache controller for one ZAP core port.
//   Read and write hits are served in the same cycle. Misses evict dirty
//   16-byte lines and fill new ones using 4-beat Wishbone bursts.
//   Uncacheable accesses become single Wishbone cycles. TLB faults are
//   reported straight back to the core. CP15 clean/invalidate requests
//   are handed to the tag RAM sequencer.
// Ports
//   i_clk, i_reset                : clock; asynchronous active-low reset
//   core side                     : i_address/i_rd/i_wr/i_din/i_ben in,
//                                   o_dat/o_ack/o_err/o_fsr/o_far out
//   CP15                          : i_cache_en, i_cache_clean/inv level
//                                   requests, o_cache_*_done one-cycle pulses
//   tag/data RAM                  : i_cache_line/tag/tag_valid/tag_dirty in,
//                                   o_cache_line/line_ben/tag/tag_dirty/
//                                   tag_wr_en out, clean/inv handshakes
//   TLB                           : i_phy_addr, i_fsr, i_far, i_fault,
//                                   i_cacheable, i_busy
//   Wishbone                      : o_wb_*_nxt (next value), o_wb_*_ff
//                                   (registered), i_wb_dat, i_wb_ack
module zap_cache_ctrl_fsm #(
  parameter int CACHE_SIZE = 1024,
  localparam int TAG_WDT = 32 - $clog2(CACHE_SIZE)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [31:0]        i_address,
  input  logic               i_rd,
  input  logic               i_wr,
  input  logic [31:0]        i_din,
  input  logic [3:0]         i_ben,
  output logic [31:0]        o_dat,
  output logic               o_ack,
  output logic               o_err,
  output logic [7:0]         o_fsr,
  output logic [31:0]        o_far,
  input  logic               i_cache_en,
  input  logic               i_cache_inv,
  input  logic               i_cache_clean,
  output logic               o_cache_inv_done,
  output logic               o_cache_clean_done,
  input  logic [127:0]       i_cache_line,
  input  logic [TAG_WDT-1:0] i_cache_tag,
  input  logic               i_cache_tag_valid,
  input  logic               i_cache_tag_dirty,
  output logic [127:0]       o_cache_line,
  output logic [15:0]        o_cache_line_ben,
  output logic [TAG_WDT-1:0] o_cache_tag,
  output logic               o_cache_tag_dirty,
  output logic               o_cache_tag_wr_en,
  output logic               o_cache_clean_req,
  output logic               o_cache_inv_req,
  input  logic               i_cache_clean_done,
  input  logic               i_cache_inv_done,
  input  logic [31:0]        i_phy_addr,
  input  logic [7:0]         i_fsr,
  input  logic [31:0]        i_far,
  input  logic               i_fault,
  input  logic               i_cacheable,
  input  logic               i_busy,
  output logic               o_wb_cyc_nxt,
  output logic               o_wb_stb_nxt,
  output logic               o_wb_wen_nxt,
  output logic [3:0]         o_wb_sel_nxt,
  output logic [31:0]        o_wb_adr_nxt,
  output logic [31:0]        o_wb_dat_nxt,
  output logic [2:0]         o_wb_cti_nxt,
  output logic               o_wb_cyc_ff,
  output logic               o_wb_stb_ff,
  output logic               o_wb_wen_ff,
  output logic [3:0]         o_wb_sel_ff,
  output logic [31:0]        o_wb_adr_ff,
  output logic [31:0]        o_wb_dat_ff,
  output logic [2:0]         o_wb_cti_ff,
  input  logic [31:0]        i_wb_dat,
  input  logic               i_wb_ack
);

  localparam int OFF_W = $clog2(CACHE_SIZE);
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [2:0] {IDLE, CLEAN, INV, SINGLE, EVICT, FETCH, REFRESH} state_t;

  state_t         state_reg, state_next;
  logic [1:0]     beat_reg, beat_next;
  logic [127:0]   fill_reg, fill_next;

  logic               access;
  logic [1:0]         word;
  logic [1:0]         next_beat;
  logic [OFF_W-5:0]   idx;
  logic [TAG_WDT-1:0] phy_tag;
  logic               hit;
  logic               unused_addr_bits;

  assign access    = i_rd | i_wr;
  assign word      = i_address[3:2];
  assign idx       = i_address[OFF_W-1:4];
  assign phy_tag   = i_phy_addr[31:OFF_W];
  assign hit       = i_cache_tag_valid && (i_cache_tag == phy_tag);
  assign next_beat = beat_reg + 2'd1;
  assign unused_addr_bits = ^{i_address[31:OFF_W], i_address[1:0]};

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_reg   <= IDLE;
      beat_reg    <= 2'd0;
      fill_reg    <= '0;
      o_wb_cyc_ff <= 1'b0;
      o_wb_stb_ff <= 1'b0;
      o_wb_wen_ff <= 1'b0;
      o_wb_sel_ff <= 4'h0;
      o_wb_adr_ff <= 32'h0;
      o_wb_dat_ff <= 32'h0;
      o_wb_cti_ff <= CTI_CLASSIC;
    end else begin
      state_reg   <= state_next;
      beat_reg    <= beat_next;
      fill_reg    <= fill_next;
      o_wb_cyc_ff <= o_wb_cyc_nxt;
      o_wb_stb_ff <= o_wb_stb_nxt;
      o_wb_wen_ff <= o_wb_wen_nxt;
      o_wb_sel_ff <= o_wb_sel_nxt;
      o_wb_adr_ff <= o_wb_adr_nxt;
      o_wb_dat_ff <= o_wb_dat_nxt;
      o_wb_cti_ff <= o_wb_cti_nxt;
    end
  end

  always_comb begin
    state_next   = state_reg;
    beat_next    = beat_reg;
    fill_next    = fill_reg;
    // Bus outputs hold by default so wait states need no extra handling.
    o_wb_cyc_nxt = o_wb_cyc_ff;
    o_wb_stb_nxt = o_wb_stb_ff;
    o_wb_wen_nxt = o_wb_wen_ff;
    o_wb_sel_nxt = o_wb_sel_ff;
    o_wb_adr_nxt = o_wb_adr_ff;
    o_wb_dat_nxt = o_wb_dat_ff;
    o_wb_cti_nxt = o_wb_cti_ff;
    o_dat              = 32'h0;
    o_ack              = 1'b0;
    o_err              = 1'b0;
    o_fsr              = 8'h0;
    o_far              = 32'h0;
    o_cache_line       = '0;
    o_cache_line_ben   = 16'h0;
    o_cache_tag        = '0;
    o_cache_tag_dirty  = 1'b0;
    o_cache_tag_wr_en  = 1'b0;
    o_cache_clean_req  = 1'b0;
    o_cache_inv_req    = 1'b0;
    o_cache_clean_done = 1'b0;
    o_cache_inv_done   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (i_cache_clean) begin
          state_next = CLEAN;
        end else if (i_cache_inv) begin
          state_next = INV;
        end else if (access && !i_busy) begin
          if (i_fault) begin
            o_ack = 1'b1;
            o_err = 1'b1;
            o_fsr = i_fsr;
            o_far = i_far;
          end else if (i_cacheable && i_cache_en) begin
            if (hit) begin
              o_ack = 1'b1;
              if (i_wr) begin
                o_cache_line      = {4{i_din}};
                o_cache_line_ben  = {12'h000, i_ben} << {word, 2'b00};
                o_cache_tag       = phy_tag;
                o_cache_tag_dirty = 1'b1;
                o_cache_tag_wr_en = 1'b1;
              end else begin
                o_dat = i_cache_line[{word, 5'b00000} +: 32];
              end
            end else begin
              beat_next    = 2'd0;
              o_wb_cyc_nxt = 1'b1;
              o_wb_stb_nxt = 1'b1;
              o_wb_sel_nxt = 4'hF;
              o_wb_cti_nxt = CTI_INCR;
              if (i_cache_tag_valid && i_cache_tag_dirty) begin
                state_next   = EVICT;
                o_wb_wen_nxt = 1'b1;
                o_wb_adr_nxt = {i_cache_tag, idx, 4'h0};
                o_wb_dat_nxt = i_cache_line[31:0];
              end else begin
                state_next   = FETCH;
                o_wb_wen_nxt = 1'b0;
                o_wb_adr_nxt = {i_phy_addr[31:4], 4'h0};
                o_wb_dat_nxt = 32'h0;
              end
            end
          end else begin
            state_next   = SINGLE;
            o_wb_cyc_nxt = 1'b1;
            o_wb_stb_nxt = 1'b1;
            o_wb_cti_nxt = CTI_CLASSIC;
            o_wb_adr_nxt = i_phy_addr;
            o_wb_sel_nxt = i_ben;
            o_wb_wen_nxt = i_wr;
            o_wb_dat_nxt = i_din;
          end
        end
      end

      CLEAN: begin
        o_cache_clean_req = 1'b1;
        if (i_cache_clean_done) begin
          o_cache_clean_done = 1'b1;
          state_next         = IDLE;
        end
      end

      INV: begin
        o_cache_inv_req = 1'b1;
        if (i_cache_inv_done) begin
          o_cache_inv_done = 1'b1;
          state_next       = IDLE;
        end
      end

      SINGLE: begin
        if (i_wb_ack) begin
          // A request withdrawn mid-transfer completes on the bus silently.
          o_ack        = access;
          o_dat        = i_wb_dat;
          o_wb_cyc_nxt = 1'b0;
          o_wb_stb_nxt = 1'b0;
          o_wb_cti_nxt = CTI_CLASSIC;
          state_next   = IDLE;
        end
      end

      EVICT: begin
        if (i_wb_ack) begin
          beat_next = next_beat;
          if (beat_reg == 2'd3) begin
            state_next   = FETCH;
            o_wb_wen_nxt = 1'b0;
            o_wb_adr_nxt = {i_phy_addr[31:4], 4'h0};
            o_wb_dat_nxt = 32'h0;
            o_wb_cti_nxt = CTI_INCR;
          end else begin
            o_wb_adr_nxt = o_wb_adr_ff + 32'd4;
            o_wb_dat_nxt = i_cache_line[{next_beat, 5'b00000} +: 32];
            o_wb_cti_nxt = (next_beat == 2'd3) ? CTI_EOB : CTI_INCR;
          end
        end
      end

      FETCH: begin
        if (i_wb_ack) begin
          beat_next = next_beat;
          fill_next[{beat_reg, 5'b00000} +: 32] = i_wb_dat;
          if (beat_reg == 2'd3) begin
            // Final beat goes straight into the RAM write; the tag comes from
            // the burst address so a withdrawn request cannot corrupt it.
            state_next        = REFRESH;
            o_wb_cyc_nxt      = 1'b0;
            o_wb_stb_nxt      = 1'b0;
            o_wb_cti_nxt      = CTI_CLASSIC;
            o_cache_line      = {i_wb_dat, fill_reg[95:0]};
            o_cache_line_ben  = 16'hFFFF;
            o_cache_tag       = o_wb_adr_ff[31:OFF_W];
            o_cache_tag_dirty = 1'b0;
            o_cache_tag_wr_en = 1'b1;
          end else begin
            o_wb_adr_nxt = o_wb_adr_ff + 32'd4;
            o_wb_cti_nxt = (next_beat == 2'd3) ? CTI_EOB : CTI_INCR;
          end
        end
      end

      REFRESH: state_next = IDLE;

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_zap_cache_ctrl_fsm.sv
// Directed testbench for zap_cache_ctrl_fsm with a simple tag/data RAM model.
module tb_zap_cache_ctrl_fsm;

  localparam int TAG_WDT = 22;

  logic i_clk = 1'b0;
  logic i_reset = 1'b0;
  always #5 i_clk = ~i_clk;

  logic [31:0] i_address = '0, i_din = '0, i_phy_addr = '0, i_far = '0, i_wb_dat = '0;
  logic        i_rd = 0, i_wr = 0, i_cache_en = 0, i_cache_inv = 0, i_cache_clean = 0;
  logic [3:0]  i_ben = '0;
  logic [7:0]  i_fsr = '0;
  logic        i_cache_clean_done = 0, i_cache_inv_done = 0;
  logic        i_fault = 0, i_cacheable = 0, i_busy = 0, i_wb_ack = 0;
  logic [127:0]       i_cache_line;
  logic [TAG_WDT-1:0] i_cache_tag;
  logic               i_cache_tag_valid, i_cache_tag_dirty;

  logic [31:0]  o_dat, o_far;
  logic         o_ack, o_err, o_cache_inv_done, o_cache_clean_done;
  logic [7:0]   o_fsr;
  logic [127:0] o_cache_line;
  logic [15:0]  o_cache_line_ben;
  logic [TAG_WDT-1:0] o_cache_tag;
  logic         o_cache_tag_dirty, o_cache_tag_wr_en, o_cache_clean_req, o_cache_inv_req;
  logic         o_wb_cyc_nxt, o_wb_stb_nxt, o_wb_wen_nxt, o_wb_cyc_ff, o_wb_stb_ff, o_wb_wen_ff;
  logic [3:0]   o_wb_sel_nxt, o_wb_sel_ff;
  logic [31:0]  o_wb_adr_nxt, o_wb_dat_nxt, o_wb_adr_ff, o_wb_dat_ff;
  logic [2:0]   o_wb_cti_nxt, o_wb_cti_ff;

  zap_cache_ctrl_fsm #(.CACHE_SIZE(1024)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_address(i_address), .i_rd(i_rd), .i_wr(i_wr), .i_din(i_din), .i_ben(i_ben),
    .o_dat(o_dat), .o_ack(o_ack), .o_err(o_err), .o_fsr(o_fsr), .o_far(o_far),
    .i_cache_en(i_cache_en), .i_cache_inv(i_cache_inv), .i_cache_clean(i_cache_clean),
    .o_cache_inv_done(o_cache_inv_done), .o_cache_clean_done(o_cache_clean_done),
    .i_cache_line(i_cache_line), .i_cache_tag(i_cache_tag),
    .i_cache_tag_valid(i_cache_tag_valid), .i_cache_tag_dirty(i_cache_tag_dirty),
    .o_cache_line(o_cache_line), .o_cache_line_ben(o_cache_line_ben),
    .o_cache_tag(o_cache_tag), .o_cache_tag_dirty(o_cache_tag_dirty),
    .o_cache_tag_wr_en(o_cache_tag_wr_en),
    .o_cache_clean_req(o_cache_clean_req), .o_cache_inv_req(o_cache_inv_req),
    .i_cache_clean_done(i_cache_clean_done), .i_cache_inv_done(i_cache_inv_done),
    .i_phy_addr(i_phy_addr), .i_fsr(i_fsr), .i_far(i_far), .i_fault(i_fault),
    .i_cacheable(i_cacheable), .i_busy(i_busy),
    .o_wb_cyc_nxt(o_wb_cyc_nxt), .o_wb_stb_nxt(o_wb_stb_nxt), .o_wb_wen_nxt(o_wb_wen_nxt),
    .o_wb_sel_nxt(o_wb_sel_nxt), .o_wb_adr_nxt(o_wb_adr_nxt), .o_wb_dat_nxt(o_wb_dat_nxt),
    .o_wb_cti_nxt(o_wb_cti_nxt),
    .o_wb_cyc_ff(o_wb_cyc_ff), .o_wb_stb_ff(o_wb_stb_ff), .o_wb_wen_ff(o_wb_wen_ff),
    .o_wb_sel_ff(o_wb_sel_ff), .o_wb_adr_ff(o_wb_adr_ff), .o_wb_dat_ff(o_wb_dat_ff),
    .o_wb_cti_ff(o_wb_cti_ff),
    .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack)
  );

  // Tag/data RAM model indexed by the core address; byte-enabled writes.
  logic [127:0]       mem_line [64];
  logic [TAG_WDT-1:0] mem_tag  [64];
  logic [63:0]        mem_valid, mem_dirty;
  logic               mem_clr = 1'b1;
  logic [5:0]         ridx;

  assign ridx              = i_address[9:4];
  assign i_cache_line      = mem_line[ridx];
  assign i_cache_tag       = mem_tag[ridx];
  assign i_cache_tag_valid = mem_valid[ridx];
  assign i_cache_tag_dirty = mem_dirty[ridx];

  always @(posedge i_clk) begin
    if (mem_clr) begin
      mem_valid <= '0;
      mem_dirty <= '0;
    end else if (o_cache_tag_wr_en) begin
      for (int b = 0; b < 16; b++)
        if (o_cache_line_ben[b]) mem_line[ridx][8*b +: 8] <= o_cache_line[8*b +: 8];
      mem_tag[ridx]   <= o_cache_tag;
      mem_valid[ridx] <= 1'b1;
      mem_dirty[ridx] <= o_cache_tag_dirty;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge i_clk);
  endtask

  logic [31:0] fdat [4];
  logic [31:0] gdat [4];
  logic [31:0] ew   [4];

  initial begin
    fdat[0] = 32'h1111_0000; fdat[1] = 32'h2222_0001;
    fdat[2] = 32'h3333_0002; fdat[3] = 32'h4444_0003;
    gdat[0] = 32'hA0A0_5000; gdat[1] = 32'hB1B1_5004;
    gdat[2] = 32'hC2C2_5008; gdat[3] = 32'hD3D3_500C;
    ew[0] = fdat[0]; ew[1] = {fdat[1][31:16], 16'hBEEF}; ew[2] = fdat[2]; ew[3] = fdat[3];

    // Reset state
    sample();
    check("rst_cyc_ff", o_wb_cyc_ff, 1'b0);
    check("rst_cti_ff", o_wb_cti_ff, 3'b000);
    check("rst_adr_ff", o_wb_adr_ff, 32'h0);
    check("rst_ack", o_ack, 1'b0);
    next_cycle();
    i_reset = 1'b1;
    mem_clr = 1'b0;

    // Cold read miss at 0x100 -> 4-beat fill, with one wait state on beat 1
    next_cycle();
    i_address = 32'h100; i_phy_addr = 32'h100; i_rd = 1; i_cacheable = 1; i_cache_en = 1;
    sample();
    check("cold_ack_idle", o_ack, 1'b0);
    check("cold_cyc_nxt", o_wb_cyc_nxt, 1'b1);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      if (k == 1) begin
        i_wb_ack = 0;
        sample();
        check("fill_wait_adr_ff", o_wb_adr_ff, 32'h104);
        next_cycle();
      end
      i_wb_ack = 1; i_wb_dat = fdat[k];
      sample();
      check($sformatf("fill%0d_adr", k), o_wb_adr_ff, 32'h100 + 32'(4*k));
      check($sformatf("fill%0d_cti", k), o_wb_cti_ff, (k == 3) ? 3'b111 : 3'b010);
      check($sformatf("fill%0d_wen", k), {o_wb_cyc_ff, o_wb_wen_ff}, 2'b10);
      if (k == 3) begin
        check("fill_wr_en", o_cache_tag_wr_en, 1'b1);
        check("fill_ben", o_cache_line_ben, 16'hFFFF);
        check("fill_dirty", o_cache_tag_dirty, 1'b0);
        check("fill_line", o_cache_line, {fdat[3], fdat[2], fdat[1], fdat[0]});
      end
    end
    next_cycle();
    i_wb_ack = 0;
    sample();
    check("refresh_cyc_ff", o_wb_cyc_ff, 1'b0);
    check("refresh_ack", o_ack, 1'b0);
    next_cycle();
    sample();
    check("cold_hit_ack", o_ack, 1'b1);
    check("cold_hit_dat", o_dat, fdat[0]);

    // Write hit 0x104
    next_cycle();
    i_rd = 0; i_wr = 1; i_address = 32'h104; i_phy_addr = 32'h104;
    i_din = 32'hDEADBEEF; i_ben = 4'b0011;
    sample();
    check("wrhit_ack", o_ack, 1'b1);
    check("wrhit_ben", o_cache_line_ben, 16'h0030);
    check("wrhit_dirty", {o_cache_tag_dirty, o_cache_tag_wr_en}, 2'b11);
    check("wrhit_line", o_cache_line, {4{32'hDEADBEEF}});
    check("wrhit_cyc_nxt", o_wb_cyc_nxt, 1'b0);

    // Miss on dirty line (tag 0, idx 16) from 0x500 -> evict then fill
    next_cycle();
    i_wr = 0; i_rd = 1; i_address = 32'h500; i_phy_addr = 32'h500;
    sample();
    check("evict_ack_idle", o_ack, 1'b0);
    check("evict_adr_nxt", o_wb_adr_nxt, 32'h100);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      i_wb_ack = 1;
      sample();
      check($sformatf("evict%0d_adr", k), o_wb_adr_ff, 32'h100 + 32'(4*k));
      check($sformatf("evict%0d_dat", k), o_wb_dat_ff, ew[k]);
      check($sformatf("evict%0d_ctl", k), {o_wb_wen_ff, o_wb_sel_ff, o_wb_cti_ff},
            {1'b1, 4'hF, (k == 3) ? 3'b111 : 3'b010});
    end
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      if (k == 2) i_rd = 0;   // core withdraws mid-burst
      i_wb_ack = 1; i_wb_dat = gdat[k];
      sample();
      check($sformatf("refill%0d_adr", k), o_wb_adr_ff, 32'h500 + 32'(4*k));
      check($sformatf("refill%0d_wen", k), o_wb_wen_ff, 1'b0);
      if (k == 3) begin
        check("refill_wr_en", o_cache_tag_wr_en, 1'b1);
        check("refill_tag", o_cache_tag, 22'd1);
        check("refill_line", o_cache_line, {gdat[3], gdat[2], gdat[1], gdat[0]});
      end
    end
    next_cycle();
    i_wb_ack = 0;
    next_cycle();
    sample();
    check("withdrawn_ack", o_ack, 1'b0);
    check("withdrawn_cyc_nxt", o_wb_cyc_nxt, 1'b0);

    // Uncacheable single write
    next_cycle();
    i_cacheable = 0; i_wr = 1; i_address = 32'h8000_0000; i_phy_addr = 32'h8000_0000;
    i_ben = 4'b1000; i_din = 32'h1122_3344;
    sample();
    check("single_wr_cyc_nxt", o_wb_cyc_nxt, 1'b1);
    next_cycle();
    sample();
    check("single_wr_ctl", {o_wb_cyc_ff, o_wb_stb_ff, o_wb_cti_ff, o_wb_sel_ff, o_wb_wen_ff},
          {1'b1, 1'b1, 3'b000, 4'h8, 1'b1});
    check("single_wr_adr", o_wb_adr_ff, 32'h8000_0000);
    check("single_wr_dat", o_wb_dat_ff, 32'h1122_3344);
    check("single_wr_wait_ack", o_ack, 1'b0);
    next_cycle();
    i_wb_ack = 1;
    sample();
    check("single_wr_ack", o_ack, 1'b1);
    next_cycle();
    i_wb_ack = 0; i_wr = 0;
    sample();
    check("single_wr_cyc_drop", o_wb_cyc_ff, 1'b0);

    // Uncacheable single read
    next_cycle();
    i_rd = 1; i_address = 32'h8000_0010; i_phy_addr = 32'h8000_0010; i_ben = 4'hF;
    next_cycle();
    i_wb_ack = 1; i_wb_dat = 32'hCAFE_F00D;
    sample();
    check("single_rd_ack", o_ack, 1'b1);
    check("single_rd_dat", o_dat, 32'hCAFE_F00D);
    check("single_rd_wen", o_wb_wen_ff, 1'b0);
    next_cycle();
    i_wb_ack = 0; i_rd = 0;

    // Busy holds off; then TLB fault
    next_cycle();
    i_cacheable = 1; i_rd = 1; i_address = 32'h100; i_phy_addr = 32'h100; i_busy = 1;
    sample();
    check("busy_ack", o_ack, 1'b0);
    check("busy_cyc_nxt", o_wb_cyc_nxt, 1'b0);
    next_cycle();
    i_busy = 0; i_fault = 1; i_fsr = 8'h05; i_far = 32'h1234;
    sample();
    check("fault_ack_err", {o_ack, o_err}, 2'b11);
    check("fault_fsr", o_fsr, 8'h05);
    check("fault_far", o_far, 32'h1234);
    check("fault_cyc_nxt", o_wb_cyc_nxt, 1'b0);
    next_cycle();
    i_rd = 0; i_fault = 0;

    // Clean and invalidate requested together
    next_cycle();
    i_cache_clean = 1; i_cache_inv = 1;
    next_cycle();
    sample();
    check("clean_req", {o_cache_clean_req, o_cache_inv_req}, 2'b10);
    next_cycle();
    i_cache_clean_done = 1;
    sample();
    check("clean_done_pulse", {o_cache_clean_done, o_cache_inv_done}, 2'b10);
    next_cycle();
    i_cache_clean = 0; i_cache_clean_done = 0;
    sample();
    check("clean_idle_reqs", {o_cache_clean_req, o_cache_inv_req}, 2'b00);
    next_cycle();
    sample();
    check("inv_req", {o_cache_clean_req, o_cache_inv_req}, 2'b01);
    next_cycle();
    i_cache_inv_done = 1;
    sample();
    check("inv_done_pulse", {o_cache_clean_done, o_cache_inv_done, o_ack}, 3'b010);
    next_cycle();
    i_cache_inv = 0; i_cache_inv_done = 0;
    sample();
    check("inv_idle_req", o_cache_inv_req, 1'b0);

    // Reset during a fill burst
    next_cycle();
    i_rd = 1; i_address = 32'h200; i_phy_addr = 32'h200;
    next_cycle();
    i_wb_ack = 1; i_wb_dat = 32'h5555_AAAA;
    sample();
    check("rstmid_cyc_before", o_wb_cyc_ff, 1'b1);
    next_cycle();
    i_wb_ack = 0; i_rd = 0;
    #2;
    i_reset = 0;
    #1;
    check("rstmid_cyc_ff", o_wb_cyc_ff, 1'b0);
    check("rstmid_cyc_nxt", o_wb_cyc_nxt, 1'b0);
    check("rstmid_adr_ff", o_wb_adr_ff, 32'h0);
    sample();
    i_reset = 1;
    next_cycle();
    i_rd = 1; i_address = 32'h500; i_phy_addr = 32'h500;
    sample();
    check("post_rst_hit_ack", o_ack, 1'b1);
    check("post_rst_hit_dat", o_dat, gdat[0]);
    next_cycle();
    i_rd = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
